// File: rtl/joust2_rom_loader_if.sv
// Download-side and ROM-write-side signal bundle for joust2_rom_loader.
// master: HPS/host side driving the download stream and sink_ready.
// slave : the loader, consuming the stream and driving the ROM write port.
interface joust2_rom_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] ioctl_index;
    logic        sink_ready;
    logic [18:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, sink_ready,
        input  dn_addr, dn_data, dn_wr
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, sink_ready,
        output dn_addr, dn_data, dn_wr
    );
endinterface

// File: rtl/joust2_rom_loader.sv
// ROM download filter/buffer for the williams2 core.
// Accepts in-sequence bytes for one download index, queues them in a small
// FIFO so the ROM write side can stall, tracks size/sequence/overflow errors,
// and holds the core in reset until a clean load has settled.
module joust2_rom_loader #(
    parameter logic [24:0] EXPECTED_SIZE = 25'h4A000,
    parameter logic [15:0] ROM_INDEX     = 16'd0,
    parameter int unsigned RESET_HOLD    = 16,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                 clock_12,
    input  logic                 reset_n,
    joust2_rom_loader_if.slave   bus,
    output logic                 core_reset,
    output logic                 load_done,
    output logic [2:0]           load_error,
    output logic [15:0]          checksum
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned HW = $clog2(RESET_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            dl_q;
    logic [24:0]     cnt_q, cnt_d;
    logic [24:0]     exp_q, exp_d;
    logic [15:0]     csum_q, csum_d;
    logic [2:0]      err_q, err_d;
    logic            done_q, done_d;
    logic            creset_q, creset_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [18:0]     dn_addr_q, dn_addr_d;
    logic [7:0]      dn_data_q, dn_data_d;
    logic            dn_wr_q, dn_wr_d;
    logic [26:0]     mem_q [FIFO_DEPTH];

    logic            index_ok;
    logic            start;
    logic            fall;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            wr_ok;
    logic            seq_ok;
    logic            push;
    logic            seq_err;
    logic            ovf;
    logic [26:0]     head;

    // Edge detection, FIFO status and the accept/pop decisions for this cycle.
    always_comb begin
        index_ok   = (bus.ioctl_index == ROM_INDEX);
        start      = bus.ioctl_download && !dl_q && index_ok;
        fall       = !bus.ioctl_download && dl_q;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
        // A starting download flushes the FIFO, so nothing is popped that cycle.
        pop        = ((state_q == S_LOAD) || (state_q == S_DRAIN)) && !fifo_empty &&
                     bus.sink_ready && !start;
        wr_ok      = (state_q == S_LOAD) && bus.ioctl_wr && index_ok && !start;
        seq_ok     = (bus.ioctl_addr[24:19] == 6'd0) && (bus.ioctl_addr == exp_q);
        push       = wr_ok && seq_ok && (!fifo_full || pop);
        seq_err    = wr_ok && !seq_ok;
        ovf        = wr_ok && seq_ok && fifo_full && !pop;
        head       = mem_q[rd_ptr_q];
    end

    // Next-state and datapath updates; a start edge overrides everything else.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        csum_d    = csum_q;
        err_d     = err_q;
        done_d    = done_q;
        creset_d  = creset_q;
        hold_d    = hold_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dn_addr_d = dn_addr_q;
        dn_data_d = dn_data_q;
        dn_wr_d   = 1'b0;

        if (start) begin
            state_d  = S_LOAD;
            cnt_d    = '0;
            exp_d    = '0;
            csum_d   = '0;
            err_d    = '0;
            done_d   = 1'b0;
            creset_d = 1'b1;
            hold_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 25'd1;
                exp_d    = exp_q + 25'd1;
                csum_d   = csum_q + {8'h00, bus.ioctl_dout};
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                dn_addr_d = head[26:8];
                dn_data_d = head[7:0];
                dn_wr_d   = 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (AW+1)'(1);
            end
            if (seq_err) begin
                err_d[2] = 1'b1;
            end
            if (ovf) begin
                err_d[1] = 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                end
                S_LOAD: begin
                    if (fall) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Empty FIFO implies no pop this cycle, so the last write is out.
                    if (fifo_empty) begin
                        state_d = S_HOLD;
                        hold_d  = '0;
                        if (cnt_q != EXPECTED_SIZE) begin
                            err_d[0] = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_q == HW'(RESET_HOLD - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                S_DONE: begin
                    done_d   = 1'b1;
                    creset_d = (err_q != 3'b000);
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and control registers with asynchronous active-low reset.
    always_ff @(posedge clock_12 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            dl_q      <= 1'b0;
            cnt_q     <= '0;
            exp_q     <= '0;
            csum_q    <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
            creset_q  <= 1'b1;
            hold_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dn_addr_q <= '0;
            dn_data_q <= '0;
            dn_wr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dl_q      <= bus.ioctl_download;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            csum_q    <= csum_d;
            err_q     <= err_d;
            done_q    <= done_d;
            creset_q  <= creset_d;
            hold_q    <= hold_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dn_addr_q <= dn_addr_d;
            dn_data_q <= dn_data_d;
            dn_wr_q   <= dn_wr_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clock_12) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.ioctl_addr[18:0], bus.ioctl_dout};
        end
    end

    assign bus.dn_addr = dn_addr_q;
    assign bus.dn_data = dn_data_q;
    assign bus.dn_wr   = dn_wr_q;
    assign core_reset  = creset_q;
    assign load_done   = done_q;
    assign load_error  = err_q;
    assign checksum    = csum_q;

endmodule
